// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - front-end fetch controller: PC ownership, return capture, decode skid, redirects
// Returns are accepted only for the single request issued in the previous cycle.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        STALL,
   input  logic        JMP_VALID,
   input  logic [31:0] JMP_PC,
   output logic        PC_VALID,
   output logic [31:0] PC,
   input  logic        MEM_WAIT,
   input  logic        INST_VALID,
   input  logic [31:0] INST,
   output logic        DEC_VALID,
   output logic [31:0] DEC_PC,
   output logic [31:0] DEC_INST
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t      state;
   logic [31:0] pc_d1;
   logic        inflight;
   logic        skid_valid;
   logic [31:0] skid_pc;
   logic [31:0] skid_inst;
   logic        issue;
   logic        ret;

   // A full skid blocks new requests, so a return can never land on top of it.
   assign PC_VALID = (state == S_RUN) && !STALL && !skid_valid && !JMP_VALID;
   assign issue    = PC_VALID && !MEM_WAIT;
   assign ret      = INST_VALID && inflight;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= S_IDLE;
         PC         <= RESET_PC;
         pc_d1      <= '0;
         inflight   <= 1'b0;
         skid_valid <= 1'b0;
         skid_pc    <= '0;
         skid_inst  <= '0;
         DEC_VALID  <= 1'b0;
         DEC_PC     <= '0;
         DEC_INST   <= '0;
      end else begin
         case (state)
            S_IDLE:  state <= S_RUN;
            default: state <= S_RUN;
         endcase

         if (JMP_VALID) begin
            // Redirect kills the in-flight fetch and anything queued for decode.
            PC         <= JMP_PC & 32'hFFFF_FFFC;
            inflight   <= 1'b0;
            skid_valid <= 1'b0;
            DEC_VALID  <= 1'b0;
         end else begin
            if (issue) begin
               PC       <= PC + 32'd4;
               pc_d1    <= PC;
               inflight <= 1'b1;
            end else begin
               inflight <= 1'b0;
            end

            if (skid_valid && !STALL) begin
               DEC_VALID  <= 1'b1;
               DEC_PC     <= skid_pc;
               DEC_INST   <= skid_inst;
               skid_valid <= 1'b0;
            end else if (ret && (!DEC_VALID || !STALL)) begin
               DEC_VALID <= 1'b1;
               DEC_PC    <= pc_d1;
               DEC_INST  <= INST;
            end else if (!STALL) begin
               DEC_VALID <= 1'b0;
            end

            if (ret && DEC_VALID && STALL) begin
               skid_valid <= 1'b1;
               skid_pc    <= pc_d1;
               skid_inst  <= INST;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - table-driven bench for fetch_ctrl with a one-cycle fetch model
module tb_fetch_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        STALL = 1'b0;
   logic        JMP_VALID = 1'b0;
   logic [31:0] JMP_PC = '0;
   logic        PC_VALID;
   logic [31:0] PC;
   logic        MEM_WAIT = 1'b0;
   logic        INST_VALID = 1'b0;
   logic [31:0] INST = '0;
   logic        DEC_VALID;
   logic [31:0] DEC_PC;
   logic [31:0] DEC_INST;

   int checks = 0;
   int failures = 0;
   int overruns = 0;

   typedef struct {
      logic        stall;
      logic        jv;
      logic [31:0] jpc;
      logic        mw;
      logic        pcv;
      logic [31:0] pc;
      logic        dv;
      logic [31:0] dpc;
   } row_t;

   row_t rows[$];

   fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
      .CLK(CLK), .RST(RST), .STALL(STALL), .JMP_VALID(JMP_VALID), .JMP_PC(JMP_PC),
      .PC_VALID(PC_VALID), .PC(PC), .MEM_WAIT(MEM_WAIT), .INST_VALID(INST_VALID),
      .INST(INST), .DEC_VALID(DEC_VALID), .DEC_PC(DEC_PC), .DEC_INST(DEC_INST)
   );

   always #5 CLK = ~CLK;

   // A return must never arrive while the skid already holds an entry.
   always @(negedge CLK)
      if (!RST && dut.skid_valid && INST_VALID && dut.inflight) overruns++;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic s, input logic jv, input logic [31:0] jpc, input logic mw,
                      input logic pcv, input logic [31:0] pc, input logic dv, input logic [31:0] dpc);
      row_t r;
      r.stall = s; r.jv = jv; r.jpc = jpc; r.mw = mw;
      r.pcv = pcv; r.pc = pc; r.dv = dv; r.dpc = dpc;
      rows.push_back(r);
   endtask

   // Fetch model: a request accepted this cycle returns its word in the next one.
   task automatic step();
      logic        iss;
      logic [31:0] a;
      iss = PC_VALID && !MEM_WAIT && !RST;
      a   = PC;
      @(posedge CLK);
      #1;
      INST_VALID = iss;
      INST       = iss ? mem(a) : 32'h0;
   endtask

   task automatic run_rows(input string tag);
      for (int i = 0; i < rows.size(); i++) begin
         STALL     = rows[i].stall;
         JMP_VALID = rows[i].jv;
         JMP_PC    = rows[i].jpc;
         MEM_WAIT  = rows[i].mw;
         #1;
         chk($sformatf("%s[%0d] pc_valid", tag, i), {31'b0, PC_VALID}, {31'b0, rows[i].pcv});
         chk($sformatf("%s[%0d] pc", tag, i), PC, rows[i].pc);
         chk($sformatf("%s[%0d] dec_valid", tag, i), {31'b0, DEC_VALID}, {31'b0, rows[i].dv});
         chk($sformatf("%s[%0d] dec_pc", tag, i), DEC_PC, rows[i].dpc);
         if (rows[i].dv)
            chk($sformatf("%s[%0d] dec_inst", tag, i), DEC_INST, mem(rows[i].dpc));
         step();
      end
      rows.delete();
   endtask

   initial begin
      step();
      step();
      chk("rst pc", PC, 32'h100);
      chk("rst pc_valid", {31'b0, PC_VALID}, 32'h0);
      chk("rst dec_valid", {31'b0, DEC_VALID}, 32'h0);
      chk("rst dec_pc", DEC_PC, 32'h0);
      chk("rst dec_inst", DEC_INST, 32'h0);
      RST = 1'b0;

      // Startup and steady streaming from 0x100.
      add(0,0,0,0, 0,32'h100,0,32'h0);
      add(0,0,0,0, 1,32'h100,0,32'h0);
      add(0,0,0,0, 1,32'h104,0,32'h0);
      add(0,0,0,0, 1,32'h108,1,32'h100);
      add(0,0,0,0, 1,32'h10C,1,32'h104);
      // Redirect to 0x1000 then a 20-cycle page miss.
      add(0,1,32'h1000,0, 0,32'h110,1,32'h108);
      for (int k = 0; k < 20; k++) add(0,0,0,1, 1,32'h1000,0,32'h108);
      add(0,0,0,0, 1,32'h1000,0,32'h108);
      add(0,0,0,0, 1,32'h1004,0,32'h108);
      add(0,0,0,0, 1,32'h1008,1,32'h1000);
      // One-cycle stall right after 0x200 issues, with 0x1FC on decode.
      add(0,1,32'h1F8,0, 0,32'h100C,1,32'h1004);
      add(0,0,0,0, 1,32'h1F8,0,32'h1004);
      add(0,0,0,0, 1,32'h1FC,0,32'h1004);
      add(0,0,0,0, 1,32'h200,1,32'h1F8);
      add(1,0,0,0, 0,32'h204,1,32'h1FC);
      add(0,0,0,0, 0,32'h204,1,32'h1FC);
      add(0,0,0,0, 1,32'h204,1,32'h200);
      add(0,0,0,0, 1,32'h208,0,32'h200);
      add(0,0,0,0, 1,32'h20C,1,32'h204);
      // Redirect kills the in-flight fetch of 0x50; low bits of target dropped.
      add(0,1,32'h50,0, 0,32'h210,1,32'h208);
      add(0,0,0,0, 1,32'h50,0,32'h208);
      add(0,1,32'h3003,0, 0,32'h54,0,32'h208);
      add(0,0,0,0, 1,32'h3000,0,32'h208);
      add(0,0,0,0, 1,32'h3004,0,32'h208);
      add(0,0,0,0, 1,32'h3008,1,32'h3000);
      // Fill the skid, then redirect while still stalled.
      add(1,0,0,0, 0,32'h300C,1,32'h3004);
      add(1,1,32'h4000,0, 0,32'h300C,1,32'h3004);
      add(0,0,0,0, 1,32'h4000,0,32'h3004);
      add(0,0,0,0, 1,32'h4004,0,32'h3004);
      add(0,0,0,0, 1,32'h4008,1,32'h4000);
      // PC wrap at the top of the address space.
      add(0,1,32'hFFFF_FFFF,0, 0,32'h400C,1,32'h4004);
      add(0,0,0,0, 1,32'hFFFF_FFFC,0,32'h4004);
      add(0,0,0,0, 1,32'h0,0,32'h4004);
      add(0,0,0,0, 1,32'h4,1,32'hFFFF_FFFC);
      add(0,0,0,0, 1,32'h8,1,32'h0);
      run_rows("main");

      // Asynchronous reset mid-stream while a return is on the bus.
      chk("pre-rst inst_valid", {31'b0, INST_VALID}, 32'h1);
      RST = 1'b1;
      #1;
      chk("async rst pc", PC, 32'h100);
      chk("async rst pc_valid", {31'b0, PC_VALID}, 32'h0);
      chk("async rst dec_valid", {31'b0, DEC_VALID}, 32'h0);
      chk("async rst dec_pc", DEC_PC, 32'h0);
      chk("async rst dec_inst", DEC_INST, 32'h0);
      RST = 1'b0;
      add(0,0,0,0, 0,32'h100,0,32'h0);
      add(0,0,0,0, 1,32'h100,0,32'h0);
      add(0,0,0,0, 1,32'h104,0,32'h0);
      add(0,0,0,0, 1,32'h108,1,32'h100);
      add(0,0,0,0, 1,32'h10C,1,32'h104);
      run_rows("restart");

      chk("skid overrun count", overruns, 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
